// File: rtl/framebuffer_scanout_pkg.sv
// rtl/framebuffer_scanout_pkg.sv - shared VGA timing constants, framebuffer geometry and pixel type
package framebuffer_scanout_pkg;

  // 640x480@60 timing, counted in 25 MHz pixel ticks
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;

  // Framebuffer geometry shared with the renderer: each stored pixel is a 2x2 screen block
  localparam int FB_WIDTH_C   = 320;
  localparam int FB_HEIGHT_C  = 240;
  localparam int FB_ADDR_W    = 17;

  // Fixed read latency of the framebuffer BRAM, in system clocks
  localparam int BRAM_LATENCY = 2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // y*320 + x built from shifts; inputs are already the halved screen coordinates
  function automatic logic [FB_ADDR_W-1:0] fb_pixel_addr(input logic [8:0] y, input logic [8:0] x);
    logic [FB_ADDR_W-1:0] ye;
    logic [FB_ADDR_W-1:0] xe;
    ye = {8'b0, y};
    xe = {8'b0, x};
    return (ye << 8) + (ye << 6) + xe;
  endfunction

endpackage

// File: rtl/framebuffer_scanout_vga_timing.sv
// rtl/framebuffer_scanout_vga_timing.sv - pixel-tick divider, h/v counters and raw sync/active
module framebuffer_scanout_vga_timing
  import framebuffer_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       tick_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       active_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [PW-1:0] phase_q, phase_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          tick;

  assign tick = (phase_q == '0);

  // Next counter values: phase wraps every clock, h/v only move on a pixel tick
  always_comb begin
    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    h_d     = h_q;
    v_d     = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Counter registers with synchronous reset to the top-left of the frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign tick_o   = tick;
  assign hcount_o = h_q;
  assign vcount_o = v_q;
  assign hs_o     = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_o     = !((v_q >= VS_START) && (v_q < VS_END));
  assign active_o = (h_q < H_ACT) && (v_q < V_ACT);

endmodule

// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - framebuffer fetch, registered RGB444/sync output and tear-free bank swap
module framebuffer_scanout
  import framebuffer_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int FB_WIDTH = FB_WIDTH_C
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  output logic [FB_ADDR_W-1:0] fb_addr_out,
  output logic                 fb_bank_out,
  input  logic [11:0]          fb_data_in,
  input  logic                 swap_req_in,
  output logic                 swap_done_out,
  output logic                 frame_start_out,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs
);

  // Read data must be back before the next pixel tick samples it
  if (BRAM_LATENCY >= CLK_DIV) begin : g_latency_check
    $error("framebuffer_scanout: BRAM latency must be below CLK_DIV");
  end
  // The address multiply is hard-wired as (y<<8)+(y<<6)
  if (FB_WIDTH != 320) begin : g_width_check
    $error("framebuffer_scanout: address generation assumes a 320-pixel framebuffer row");
  end

  localparam logic [9:0] V_BLANK_START = 10'(V_ACTIVE);

  logic       tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hs_raw;
  logic       vs_raw;
  logic       active;

  framebuffer_scanout_vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .tick_o   (tick),
    .hcount_o (hcount),
    .vcount_o (vcount),
    .hs_o     (hs_raw),
    .vs_o     (vs_raw),
    .active_o (active)
  );

  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 bank_q, bank_d;
  logic                 swap_done_q, swap_done_d;
  logic                 frame_start_q, frame_start_d;
  logic                 act_d1_q, act_d1_d;
  logic                 hs_d1_q, hs_d1_d;
  logic                 vs_d1_q, vs_d1_d;
  rgb444_t              rgb_q, rgb_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;

  // Per-tick pipeline: issue the address, then one tick later capture colour with the matching sync
  always_comb begin
    addr_d        = addr_q;
    bank_d        = bank_q;
    swap_done_d   = 1'b0;
    frame_start_d = 1'b0;
    act_d1_d      = act_d1_q;
    hs_d1_d       = hs_d1_q;
    vs_d1_d       = vs_d1_q;
    rgb_d         = rgb_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    if (tick) begin
      if (active) begin
        addr_d = fb_pixel_addr(vcount[9:1], hcount[9:1]);
      end
      act_d1_d = active;
      hs_d1_d  = hs_raw;
      vs_d1_d  = vs_raw;
      rgb_d    = act_d1_q ? rgb444_t'(fb_data_in) : '0;
      hs_d     = hs_d1_q;
      vs_d     = vs_d1_q;
      if ((hcount == '0) && (vcount == V_BLANK_START) && swap_req_in) begin
        bank_d      = ~bank_q;
        swap_done_d = 1'b1;
      end
      if ((hcount == '0) && (vcount == '0)) begin
        frame_start_d = 1'b1;
      end
    end
  end

  // Output and pipeline registers; reset drops any pending swap and blanks the display
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q        <= '0;
      bank_q        <= 1'b0;
      swap_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      act_d1_q      <= 1'b0;
      hs_d1_q       <= 1'b1;
      vs_d1_q       <= 1'b1;
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      addr_q        <= addr_d;
      bank_q        <= bank_d;
      swap_done_q   <= swap_done_d;
      frame_start_q <= frame_start_d;
      act_d1_q      <= act_d1_d;
      hs_d1_q       <= hs_d1_d;
      vs_d1_q       <= vs_d1_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign fb_addr_out     = addr_q;
  assign fb_bank_out     = bank_q;
  assign swap_done_out   = swap_done_q;
  assign frame_start_out = frame_start_q;
  assign vga_r           = rgb_q.r;
  assign vga_g           = rgb_q.g;
  assign vga_b           = rgb_q.b;
  assign vga_hs          = hs_q;
  assign vga_vs          = vs_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - directed self-checking bench for framebuffer_scanout on a reduced raster
module tb_framebuffer_scanout;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = 24;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2, VT = 14;
  localparam int DIV = 4;
  localparam int FRAME = DIV * HT * VT;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [16:0] fb_addr_out;
  logic        fb_bank_out;
  logic [11:0] fb_data_in;
  logic        swap_req_in;
  logic        swap_done_out;
  logic        frame_start_out;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  logic [11:0] bram_d1, bram_d2;
  logic        force_fff;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc;
  int fs_cnt = 0, sd_cnt = 0, fs_first = 0, fs_second = 0;
  int hs_low = 0, vs_low = 0;
  logic meas_en = 1'b1;

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CLK_DIV  (DIV), .FB_WIDTH (320)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .fb_addr_out     (fb_addr_out),
    .fb_bank_out     (fb_bank_out),
    .fb_data_in      (fb_data_in),
    .swap_req_in     (swap_req_in),
    .swap_done_out   (swap_done_out),
    .frame_start_out (frame_start_out),
    .vga_r           (vga_r),
    .vga_g           (vga_g),
    .vga_b           (vga_b),
    .vga_hs          (vga_hs),
    .vga_vs          (vga_vs)
  );

  // BRAM model: data = address[11:0], two-clock read latency, optionally forced to all ones
  always @(posedge clk) begin
    bram_d1 <= fb_addr_out[11:0];
    bram_d2 <= bram_d1;
  end
  assign fb_data_in = bram_d2 | (force_fff ? 12'hFFF : 12'h000);

  always @(posedge clk) begin
    if (rst_in) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_in) begin
      if (frame_start_out) begin
        fs_cnt <= fs_cnt + 1;
        if (fs_cnt == 0) fs_first  <= ncyc;
        if (fs_cnt == 1) fs_second <= ncyc;
      end
      if (swap_done_out) sd_cnt <= sd_cnt + 1;
      if (meas_en && ncyc >= 1 && ncyc <= FRAME) begin
        hs_low <= hs_low + (vga_hs ? 0 : 1);
        vs_low <= vs_low + (vga_vs ? 0 : 1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ncyc value just after the pixel tick of (h,v) in frame f counted from reset release
  function automatic int at(input int h, input int v, input int f);
    return DIV * (v * HT + h) + 1 + FRAME * f;
  endfunction

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (ncyc != target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (ncyc != target) check("wait_timeout", ncyc, target);
  endtask

  initial begin
    rst_in      = 1'b1;
    swap_req_in = 1'b0;
    force_fff   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr",   fb_addr_out, 0);
    check("rst_bank",   fb_bank_out, 0);
    check("rst_rgb",    {vga_r, vga_g, vga_b}, 0);
    check("rst_hs",     vga_hs, 1);
    check("rst_vs",     vga_vs, 1);
    check("rst_swapd",  swap_done_out, 0);
    check("rst_fstart", frame_start_out, 0);
    rst_in = 1'b0;

    wait_cyc(at(0, 0, 0));
    check("fstart_pulse", frame_start_out, 1);
    wait_cyc(at(0, 0, 0) + 1);
    check("fstart_width", frame_start_out, 0);

    wait_cyc(at(3, 2, 0));
    check("addr_3_2", fb_addr_out, 321);
    wait_cyc(at(4, 2, 0));
    check("rgb_3_2", {vga_r, vga_g, vga_b}, 12'h141);

    wait_cyc(at(0, 3, 0));
    swap_req_in = 1'b1;
    wait_cyc(at(15, 3, 0));
    check("addr_15_3", fb_addr_out, 327);
    wait_cyc(at(16, 3, 0));
    check("addr_hold_blank", fb_addr_out, 327);
    check("rgb_15_3", {vga_r, vga_g, vga_b}, 12'h147);
    force_fff = 1'b1;
    wait_cyc(at(17, 3, 0));
    check("rgb_hblank", {vga_r, vga_g, vga_b}, 0);
    wait_cyc(at(18, 3, 0));
    check("hs_before", vga_hs, 1);
    wait_cyc(at(19, 3, 0));
    check("hs_low", vga_hs, 0);
    wait_cyc(at(0, 4, 0));
    force_fff = 1'b0;

    wait_cyc(at(5, 7, 0));
    check("addr_5_7", fb_addr_out, 962);
    wait_cyc(at(6, 7, 0));
    check("rgb_5_7", {vga_r, vga_g, vga_b}, 12'h3C2);
    wait_cyc(at(15, 7, 0));
    check("addr_last", fb_addr_out, 967);

    wait_cyc(at(0, 8, 0) - 1);
    check("bank_pre_swap", fb_bank_out, 0);
    check("swapd_pre", swap_done_out, 0);
    wait_cyc(at(0, 8, 0));
    check("swapd_pulse0", swap_done_out, 1);
    check("bank_swap0", fb_bank_out, 1);
    force_fff = 1'b1;
    wait_cyc(at(0, 8, 0) + 1);
    check("swapd_width", swap_done_out, 0);
    wait_cyc(at(1, 8, 0));
    check("rgb_vblank", {vga_r, vga_g, vga_b}, 0);
    wait_cyc(at(0, 10, 0));
    check("vs_before", vga_vs, 1);
    wait_cyc(at(1, 10, 0));
    check("vs_low", vga_vs, 0);
    wait_cyc(at(0, 13, 0));
    force_fff = 1'b0;

    wait_cyc(at(0, 0, 1));
    check("fstart_f1", frame_start_out, 1);
    wait_cyc(at(1, 0, 1));
    meas_en = 1'b0;
    check("frame_period", fs_second - fs_first, FRAME);
    check("hs_low_clks", hs_low, VT * HS * DIV);
    check("vs_low_clks", vs_low, VS * HT * DIV);

    wait_cyc(at(0, 8, 1));
    check("swapd_pulse1", swap_done_out, 1);
    check("bank_swap1", fb_bank_out, 0);
    wait_cyc(at(0, 8, 2));
    check("bank_swap2", fb_bank_out, 1);
    wait_cyc(at(1, 8, 2));
    check("fstart_count", fs_cnt, 3);
    check("swapd_count", sd_cnt, 3);

    wait_cyc(at(20, 5, 3));
    check("pre_rst_hs", vga_hs, 0);
    check("pre_rst_addr", fb_addr_out, 647);
    rst_in = 1'b1;
    @(negedge clk);
    check("mid_rst_addr",  fb_addr_out, 0);
    check("mid_rst_bank",  fb_bank_out, 0);
    check("mid_rst_hs",    vga_hs, 1);
    check("mid_rst_vs",    vga_vs, 1);
    check("mid_rst_rgb",   {vga_r, vga_g, vga_b}, 0);
    check("mid_rst_swapd", swap_done_out, 0);
    rst_in = 1'b0;

    wait_cyc(at(0, 0, 0));
    check("post_rst_fstart", frame_start_out, 1);
    wait_cyc(at(0, 8, 0) - 1);
    check("post_rst_bank", fb_bank_out, 0);
    wait_cyc(at(0, 8, 0));
    check("post_rst_swapd", swap_done_out, 1);
    check("post_rst_bank_sw", fb_bank_out, 1);
    wait_cyc(at(1, 8, 0));
    swap_req_in = 1'b0;
    wait_cyc(at(0, 8, 1));
    check("no_req_swapd", swap_done_out, 0);
    check("no_req_bank", fb_bank_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
